// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data memory controller.
package dmem_pkg;
  localparam int DMEM_DATA_W  = 8;
  localparam int DMEM_MAX_LAT = 15;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t;
endpackage

// File: rtl/dmem_ram.sv
// Synchronous single-port byte RAM with a registered read port (read every cycle).
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   we_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [DMEM_DATA_W-1:0] wdata_i,
  output logic [DMEM_DATA_W-1:0] rdata_o
);

  logic [DMEM_DATA_W-1:0] mem_q [2**ADDR_W];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory with request/done handshake and registered load data.
// Optional read/write commit counters are enabled by defining DMEM_PERF_CNT_EN.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   MemReq,
  input  logic                   MemWrite,
  input  logic [ADDR_W-1:0]      Addr,
  input  logic [DMEM_DATA_W-1:0] DataIn,
  output logic [DMEM_DATA_W-1:0] DataMemOut,
  output logic                   MemBusy,
  output logic                   MemDone
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [15:0]            ReadCount,
  output logic [15:0]            WriteCount
`endif
);

  localparam int CNT_W = 4;

  if (LATENCY < 1 || LATENCY > DMEM_MAX_LAT) begin : g_lat_check
    $error("data_mem_ctrl: LATENCY must be in 1..15");
  end

  dmem_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   write_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DMEM_DATA_W-1:0] wdata_q;
  logic [DMEM_DATA_W-1:0] dout_q;
  logic                   latch_req;
  logic                   commit;
  logic                   ram_we;
  logic [ADDR_W-1:0]      ram_addr;
  logic [DMEM_DATA_W-1:0] ram_rdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_req = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemReq) begin
          latch_req = 1'b1;
          cnt_d     = CNT_W'(LATENCY - 1);
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          commit  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM read runs every cycle; in IDLE it looks at the incoming address so the
  // registered rdata already holds the target byte on the commit edge even at LATENCY=1.
  assign ram_addr = (state_q == IDLE) ? Addr : addr_q;
  assign ram_we   = commit & write_q & ~Reset;

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk    (CLK),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_req) begin
        write_q <= MemWrite;
        addr_q  <= Addr;
        wdata_q <= DataIn;
      end
      if (commit && !write_q) begin
        dout_q <= ram_rdata;
      end
    end
  end

  assign DataMemOut = dout_q;
  assign MemBusy    = (state_q != IDLE);
  assign MemDone    = (state_q == DONE);

`ifdef DMEM_PERF_CNT_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (commit) begin
      if (!write_q && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (write_q && wr_cnt_q != 16'hFFFF)  wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign ReadCount  = rd_cnt_q;
  assign WriteCount = wr_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed plus randomized bench for data_mem_ctrl against a byte-array reference model.
module tb_data_mem_ctrl;
  localparam int LAT    = 2;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              Reset = 1'b1;
  logic              MemReq = 1'b0;
  logic              MemWrite = 1'b0;
  logic [ADDR_W-1:0] Addr = '0;
  logic [7:0]        DataIn = '0;
  logic [7:0]        DataMemOut;
  logic              MemBusy;
  logic              MemDone;
`ifdef DMEM_PERF_CNT_EN
  logic [15:0]       ReadCount;
  logic [15:0]       WriteCount;
`endif

  data_mem_ctrl #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .CLK       (clk),
    .Reset     (Reset),
    .MemReq    (MemReq),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .DataIn    (DataIn),
    .DataMemOut(DataMemOut),
    .MemBusy   (MemBusy),
    .MemDone   (MemDone)
`ifdef DMEM_PERF_CNT_EN
    ,
    .ReadCount (ReadCount),
    .WriteCount(WriteCount)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: byte array, written flags, architectural DataMemOut.
  logic [7:0] ref_mem [256];
  bit         written [256];
  logic [7:0] exp_dout = 8'h00;
  logic [7:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    MemReq = 1'b0;
    chk({tag, "_busy"}, 16'(MemBusy), 16'd0);
    chk({tag, "_done"}, 16'(MemDone), 16'd0);
    chk({tag, "_dout"}, 16'(DataMemOut), 16'(exp_dout));
  endtask

  // One full access presented in an IDLE cycle; optionally pulses MemReq in BUSY/DONE.
  task automatic access(input bit w, input logic [7:0] a, input logic [7:0] d, input bit pulse);
    logic [7:0] got;
    @(negedge clk);
    MemReq = 1'b1; MemWrite = w; Addr = a; DataIn = d;
    if (!w) exp_q.push_back(ref_mem[a]);
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      MemReq   = pulse && (c == 1 || c == LAT + 1);
      MemWrite = 1'($urandom_range(0, 1));
      Addr     = 8'($urandom);
      DataIn   = 8'($urandom);
      chk("busy", 16'(MemBusy), 16'd1);
      chk("done", 16'(MemDone), (c == LAT + 1) ? 16'd1 : 16'd0);
      if (c <= LAT) chk("dout_hold", 16'(DataMemOut), 16'(exp_dout));
    end
    if (w) begin
      ref_mem[a] = d;
      written[a] = 1'b1;
    end else begin
      got = exp_q.pop_front();
      exp_dout = got;
    end
    chk(w ? "dout_after_store" : "dout_load", 16'(DataMemOut), 16'(exp_dout));
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] addr_set [4];
    bit w;
    addr_set[0] = 8'h00; addr_set[1] = 8'h10; addr_set[2] = 8'h7F; addr_set[3] = 8'hFF;

    // Reset then idle
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) idle_cycle("reset_idle");

    // Store/load/store sequence; DataMemOut must hold across the store
    access(1'b1, 8'h10, 8'hA5, 1'b0);
    access(1'b0, 8'h10, 8'h00, 1'b0);
    access(1'b1, 8'h11, 8'h3C, 1'b0);
    chk("hold_A5", 16'(DataMemOut), 16'h00A5);

    // Requests during BUSY/DONE ignored; back-to-back acceptance in first IDLE cycle
    access(1'b1, 8'h20, 8'h77, 1'b1);
    access(1'b0, 8'h20, 8'h00, 1'b1);
    idle_cycle("ignored_req");

    // Boundary addresses, overwrite
    access(1'b1, 8'hFF, 8'h01, 1'b0);
    access(1'b1, 8'hFF, 8'h02, 1'b0);
    access(1'b1, 8'h00, 8'h5A, 1'b0);
    access(1'b0, 8'hFF, 8'h00, 1'b0);
    access(1'b0, 8'h00, 8'h00, 1'b0);

    // Reset aborts a pending store in BUSY (on what would be its commit edge)
    access(1'b1, 8'h30, 8'h55, 1'b0);
    idle_cycle("pre_abort");
    @(negedge clk);
    MemReq = 1'b1; MemWrite = 1'b1; Addr = 8'h30; DataIn = 8'h99;
    @(negedge clk);
    MemReq = 1'b0;
    chk("abort_busy1", 16'(MemBusy), 16'd1);
    @(negedge clk);
    chk("abort_busy2", 16'(MemBusy), 16'd1);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    exp_dout = 8'h00;
    chk("abort_idle", 16'(MemBusy), 16'd0);
    chk("abort_nodone", 16'(MemDone), 16'd0);
    chk("abort_dout_cleared", 16'(DataMemOut), 16'd0);
    idle_cycle("post_abort");
    access(1'b0, 8'h30, 8'h00, 1'b0);
    chk("abort_kept_55", 16'(DataMemOut), 16'h0055);

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 1) == 0) ? addr_set[$urandom_range(0, 3)] : 8'($urandom);
      w = !written[a] || ($urandom_range(0, 1) == 1);
      access(w, a, 8'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_cycle("rand_idle");
    end

`ifdef DMEM_PERF_CNT_EN
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    exp_dout = 8'h00;
    chk("perf_rd_reset", ReadCount, 16'h0000);
    force dut.wr_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.wr_cnt_q;
    for (int i = 0; i < 3; i++) access(1'b1, 8'h40 + 8'(i), 8'(i), 1'b0);
    chk("perf_wr_sat", WriteCount, 16'hFFFF);
    access(1'b0, 8'h40, 8'h00, 1'b0);
    access(1'b0, 8'h41, 8'h00, 1'b0);
    chk("perf_rd_2", ReadCount, 16'd2);
    chk("perf_wr_still_sat", WriteCount, 16'hFFFF);
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    chk("perf_rd_clr", ReadCount, 16'h0000);
    chk("perf_wr_clr", WriteCount, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
